fft_din_pingpong: RTL
=====================

# fft_din_pingpong

Two-frame ping-pong buffer between the USB interface and the FFT core. It accepts whole parallel input frames (2^NPOINT complex samples) on a valid/busy handshake, stores up to two frames, and presents them in order to the FFT core on a second valid/busy handshake. It withholds frames from the core until the full twiddle-weight set has been streamed, so the core never starts on stale weights. The upstream USB interface keeps reading the next frame while the core is busy with the current one.

## Interface
- NPOINT, 3, log2 of FFT points; frame = 2^NPOINT complex samples
- DW, 16, bits per real or imaginary sample
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- weight_valid  in  1  one pulse per complex weight delivered to the core
- weight_clear  in  1  one-cycle pulse: restart the weight count (new weight load follows)
- weight_done  out  1  full weight set received
- din_valid  in  1  input frame valid
- din_busy  out  1  buffer cannot accept a frame
- din_real / din_imag  in  DW*2^NPOINT each  input frame, sample k at [k*DW +: DW]
- dout_valid  out  1  output frame valid
- dout_busy  in  1  FFT core cannot accept
- dout_real / dout_imag  out  DW*2^NPOINT each  output frame, same packing
- level  out  2  frames stored (0, 1, 2)
- frame_cnt  out  16  frames delivered downstream, wraps mod 2^16

## Operation
- Storage: two banks (A/B), each real+imag frame registers, plus wr_ptr, rd_ptr (1 bit each) and level.
- Upstream transfer: din_valid && !din_busy in a cycle; frame written to bank[wr_ptr], wr_ptr toggles.
- Downstream transfer: dout_valid && !dout_busy; bank[rd_ptr] released, rd_ptr toggles, frame_cnt increments.
- level_next = level + in_xfer - out_xfer. Simultaneous in/out: level unchanged, both pointers toggle.
- din_busy is registered: din_busy <= (level_next == 2). A frame offered while busy is held by the sender, never dropped.
- dout_valid is registered: dout_valid <= weight_done_next && (level_next != 0).
- dout_real/imag = bank[rd_ptr] (register mux); stable whenever dout_valid=1 and dout_busy=1.
- Weight gate: WEIGHT_NUM = NPOINT*2^(NPOINT-1) (12 for NPOINT=3). weight_cnt counts weight_valid pulses; weight_done sets on the pulse that brings the count to WEIGHT_NUM. After that, weight_cnt saturates and further pulses are ignored.
- weight_clear: weight_cnt <= 0 and weight_done <= 0 next cycle. Stored frames are kept, and dout_valid deasserts next cycle. This is the only case dout_valid falls without a transfer.
  - weight_clear and weight_valid in the same cycle: clear wins and the pulse is not counted.
- Frames are accepted regardless of weight_done; only delivery is gated.

## Timing
- Reset (async, rst=1): banks, pointers, level, weight_cnt, frame_cnt = 0; weight_done=0, din_busy=0, dout_valid=0, dout data=0.
- Input-to-output latency with weights loaded and buffer empty: frame accepted at edge N, dout_valid=1 after edge N, so the core can take it at edge N+1.
- Full: after the second accept with no drain, din_busy=1 from the next cycle. The first out_xfer clears din_busy on the same edge it frees the bank, so a new frame is accepted one cycle later.
- Weight completion: the weight_valid pulse counted at edge N sets weight_done after N. If level != 0, dout_valid rises on the same edge.
- Reset mid-operation: all stored frames are discarded and the weight set must be re-sent.

## Test plan
- Reset, 12 weight_valid pulses, one frame with samples real=k, imag=0x100+k -> weight_done=1 after the 12th pulse; dout_valid=1 one cycle after the accept; dout equals din; frame_cnt=1.
- Two frames sent before any weights -> both accepted, din_busy=1, level=2, dout_valid=0. Then 12 weights -> frame 1 then frame 2 delivered in order with dout_busy=0; level returns to 0.
- dout_busy held high with level=2, third frame offered -> third frame held upstream. Release dout_busy for one cycle -> din_busy drops, third frame accepted next cycle, delivery order 1,2,3.
- Continuous streaming at one frame per cycle with dout_busy=0 -> simultaneous in/out every cycle, level stays 1, no frame lost or duplicated over 1000 frames, frame_cnt=1000.
- weight_clear while dout_valid=1 and dout_busy=1 -> dout_valid=0 next cycle, level unchanged. 12 new weights -> same frame re-presented unchanged.
- Async rst asserted mid-transfer with level=2 -> all outputs 0 immediately; after release, din_busy=0 and weight_done=0.

Source files
------------

// File: rtl/fft_din_pingpong.sv
// fft_din_pingpong
// Two-frame ping-pong buffer between the USB interface and the FFT core.
// Whole frames of 2^NPOINT complex samples are accepted on a valid/busy
// handshake, held in two banks, and presented in arrival order to the FFT
// core on a second valid/busy handshake. Delivery is withheld until the full
// twiddle-weight set has been counted, so the core never starts on stale
// weights; acceptance of frames is not gated.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   weight_valid              one pulse per complex weight sent to the core
//   weight_clear              restart the weight count (new load follows)
//   weight_done               full weight set received
//   din_valid / din_busy      upstream handshake
//   din_real / din_imag       input frame, sample k at [k*DW +: DW]
//   dout_valid / dout_busy    downstream handshake
//   dout_real / dout_imag     output frame, same packing
//   level                     frames stored (0..2)
//   frame_cnt                 frames delivered downstream, wraps mod 2^16
module fft_din_pingpong #(
    parameter int NPOINT = 3,
    parameter int DW     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        weight_valid,
    input  logic                        weight_clear,
    output logic                        weight_done,
    input  logic                        din_valid,
    output logic                        din_busy,
    input  logic [DW*(2**NPOINT)-1:0]   din_real,
    input  logic [DW*(2**NPOINT)-1:0]   din_imag,
    output logic                        dout_valid,
    input  logic                        dout_busy,
    output logic [DW*(2**NPOINT)-1:0]   dout_real,
    output logic [DW*(2**NPOINT)-1:0]   dout_imag,
    output logic [1:0]                  level,
    output logic [15:0]                 frame_cnt
);

    localparam int FW         = DW * (2**NPOINT);
    localparam int WEIGHT_NUM = NPOINT * (2**(NPOINT-1));
    localparam int WCW        = $clog2(WEIGHT_NUM + 1);

    logic [FW-1:0]  bank_real_reg [2];
    logic [FW-1:0]  bank_imag_reg [2];
    logic           wr_ptr_reg;
    logic           rd_ptr_reg;
    logic [1:0]     level_reg;
    logic [1:0]     level_next;
    logic [WCW-1:0] weight_cnt_reg;
    logic [WCW-1:0] weight_cnt_next;
    logic           weight_done_reg;
    logic           weight_done_next;
    logic           din_busy_reg;
    logic           dout_valid_reg;
    logic [15:0]    frame_cnt_reg;
    logic           in_xfer;
    logic           out_xfer;

    always_comb begin
        in_xfer  = din_valid && !din_busy_reg;
        out_xfer = dout_valid_reg && !dout_busy;

        // Clear wins over a coincident weight pulse; the count saturates at
        // the full set so extra pulses cannot wrap it back below done.
        weight_cnt_next = weight_cnt_reg;
        if (weight_clear) begin
            weight_cnt_next = '0;
        end else if (weight_valid && (weight_cnt_reg != WCW'(WEIGHT_NUM))) begin
            weight_cnt_next = weight_cnt_reg + WCW'(1);
        end
        weight_done_next = (weight_cnt_next == WCW'(WEIGHT_NUM));

        level_next = level_reg;
        if (in_xfer && !out_xfer) begin
            level_next = level_reg + 2'd1;
        end else if (out_xfer && !in_xfer) begin
            level_next = level_reg - 2'd1;
        end
    end

    // One storage bank per pointer value; a bank is only ever written while
    // it is free, so the bank being presented downstream never changes.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    bank_real_reg[gi] <= '0;
                    bank_imag_reg[gi] <= '0;
                end else if (in_xfer && (wr_ptr_reg == 1'(gi))) begin
                    bank_real_reg[gi] <= din_real;
                    bank_imag_reg[gi] <= din_imag;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg      <= 1'b0;
            rd_ptr_reg      <= 1'b0;
            level_reg       <= 2'd0;
            weight_cnt_reg  <= '0;
            weight_done_reg <= 1'b0;
            din_busy_reg    <= 1'b0;
            dout_valid_reg  <= 1'b0;
            frame_cnt_reg   <= 16'd0;
        end else begin
            if (in_xfer) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (out_xfer) begin
                rd_ptr_reg    <= ~rd_ptr_reg;
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
            end
            level_reg       <= level_next;
            weight_cnt_reg  <= weight_cnt_next;
            weight_done_reg <= weight_done_next;
            // Both handshake outputs are registered from next-state values so
            // they line up with the storage update on the same edge.
            din_busy_reg    <= (level_next == 2'd2);
            dout_valid_reg  <= weight_done_next && (level_next != 2'd0);
        end
    end

    assign weight_done = weight_done_reg;
    assign din_busy    = din_busy_reg;
    assign dout_valid  = dout_valid_reg;
    assign dout_real   = bank_real_reg[rd_ptr_reg];
    assign dout_imag   = bank_imag_reg[rd_ptr_reg];
    assign level       = level_reg;
    assign frame_cnt   = frame_cnt_reg;

endmodule
